// File: rtl/multi_sample_pulse_generator.sv
// multi_sample_pulse_generator
//   NUM_CH independent down-counters. Each produces single-cycle sample
//   strobes with a runtime-programmable spacing of period+1 clocks. A channel
//   runs either periodically or as a one-shot.
//
//   Ports:
//     clk        system clock, all state on rising edge
//     rst_n      asynchronous active-low reset
//     wr_en      period write strobe (one cycle per write)
//     wr_ch      channel index for the write; indices >= NUM_CH are ignored
//     wr_period  new period P (pulse spacing P+1 clocks)
//     en         per-channel run enable (level, rising edge starts a channel)
//     oneshot    per-channel mode: 1 = single pulse, 0 = periodic
//     smpl       per-channel sample strobe
//     busy       per-channel counting indicator

// One channel: period register, counter and IDLE/RUN state.
module msp_chan #(
  parameter int CNT_W          = 17,
  parameter int DEFAULT_PERIOD = 24999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             en,
  input  logic             oneshot,
  output logic             smpl,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_r;
  logic             en_q;

  // Outputs decode registers only; no combinational path from inputs.
  assign busy = (state == RUN);
  assign smpl = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= DEF_P;
      period_r <= DEF_P;
      en_q     <= 1'b0;
    end else begin
      en_q <= en;
      // Every load below reads period_r before this update lands, so a
      // write coinciding with a load takes effect from the next load.
      if (wr) period_r <= wr_period;
      case (state)
        IDLE: begin
          if (en && !en_q) begin
            state <= RUN;
            cnt   <= period_r;
          end
        end
        default: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= period_r;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Terminal count: mode is sampled only here.
            cnt <= period_r;
            if (oneshot) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

module multi_sample_pulse_generator #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 17,
  parameter int DEFAULT_PERIOD = 24999,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_period,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] oneshot,
  output logic [NUM_CH-1:0] smpl,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] wr_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Full-width compare so out-of-range indices never alias a channel.
    assign wr_hit[i] = wr_en && (32'(wr_ch) == i);

    msp_chan #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr_hit[i]),
      .wr_period (wr_period),
      .en        (en[i]),
      .oneshot   (oneshot[i]),
      .smpl      (smpl[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_sample_pulse_generator.sv
module tb_multi_sample_pulse_generator;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 17;
  localparam int DEFP   = 24999;
  localparam int CH_W   = 3;   // wide enough to present out-of-range indices

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_period;
  logic [NUM_CH-1:0] en, oneshot, smpl, busy;

  int ncmp = 0;
  int nerr = 0;

  multi_sample_pulse_generator #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEFP), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .en(en), .oneshot(oneshot),
    .smpl(smpl), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model, time based: each running channel holds the absolute
  // edge number after which its next pulse cycle occurs.
  longint cyc;
  bit     m_run [NUM_CH];
  bit     m_enq [NUM_CH];
  longint m_pulse [NUM_CH];
  longint m_per [NUM_CH];

  longint ch0_start;
  longint p0_q[$];

  always @(negedge clk) if (rst_n === 1'b1 && smpl[0] === 1'b1) p0_q.push_back(cyc);

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_enq[c] = 0; m_per[c] = DEFP; m_pulse[c] = 0;
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_smpl();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_run[c] && (cyc == m_pulse[c]);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_busy();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_run[c];
    return r;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // leave time 1ns past the edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else begin
      for (int c = 0; c < NUM_CH; c++) begin
        automatic bit term = m_run[c] && (cyc - 1 == m_pulse[c]);
        if (!m_run[c]) begin
          if (en[c] && !m_enq[c]) begin m_run[c] = 1; m_pulse[c] = cyc + m_per[c]; end
        end else if (!en[c]) m_run[c] = 0;
        else if (term) begin
          if (oneshot[c]) m_run[c] = 0;
          else m_pulse[c] = cyc + m_per[c];
        end
        m_enq[c] = en[c];
        if (wr_en && int'(wr_ch) == c) m_per[c] = longint'(wr_period);
      end
    end
    #1;
  endtask

  task automatic do_wr(input int ch, input int p);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_period = CNT_W'(p);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; oneshot = '0; wr_en = 1'b0; wr_ch = '0; wr_period = '0;
    cyc = 0; model_reset();
    repeat (3) tick();
    ncmp++;
    if (smpl !== 4'b0000 || busy !== 4'b0000) begin
      nerr++; $display("FAIL reset_state smpl=%b busy=%b want 0000/0000", smpl, busy);
    end
    en = 4'b0001;
    #2 rst_n = 1'b1;
    tick();
    ch0_start = cyc;
    ncmp++;
    if (busy !== 4'b0001 || smpl !== 4'b0000) begin
      nerr++; $display("FAIL reset_release_start smpl=%b busy=%b want 0000/0001", smpl, busy);
    end
  endtask

  task automatic test_periodic();
    longint k, d;
    do_wr(1, 3);
    en[1] = 1'b1;
    tick();
    k = cyc;
    for (int i = 0; i < 14; i++) begin
      d = cyc - k;
      ncmp++;
      if (smpl[1] !== (d % 4 == 3) || smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL periodic_p3 d=%0d smpl=%b want %b busy=%b want %b",
                         d, smpl, exp_smpl(), busy, exp_busy());
      end
      tick();
    end
    en[1] = 1'b0;
    tick();
    ncmp++;
    if (busy[1] !== 1'b0) begin
      nerr++; $display("FAIL periodic_stop busy[1]=%b want 0", busy[1]);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      ncmp++;
      if (smpl[1] !== 1'b0 || smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL periodic_after_stop smpl=%b want %b busy=%b want %b",
                         smpl, exp_smpl(), busy, exp_busy());
      end
    end
  endtask

  task automatic test_oneshot();
    longint k, d;
    do_wr(2, 2);
    oneshot[2] = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      en[2] = 1'b0; tick();
      en[2] = 1'b1; tick();
      k = cyc;
      for (int i = 0; i < 8; i++) begin
        d = cyc - k;
        ncmp++;
        if (smpl[2] !== (d == 2) || busy[2] !== (d <= 2) ||
            smpl !== exp_smpl() || busy !== exp_busy()) begin
          nerr++; $display("FAIL oneshot rep=%0d d=%0d smpl=%b want %b busy=%b want %b",
                           rep, d, smpl, exp_smpl(), busy, exp_busy());
        end
        tick();
      end
    end
  endtask

  task automatic test_period_write();
    longint k, d;
    do_wr(3, 4);
    do_wr(1, 3);
    en[1] = 1'b1;
    tick();
    k = cyc;
    for (int i = 0; i < 27; i++) begin
      d = cyc - k;
      ncmp++;
      if (smpl[1] !== (d == 3 || d == 9 || d == 15 || d == 21 || d == 25) ||
          smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL period_write d=%0d smpl=%b want %b busy=%b want %b",
                         d, smpl, exp_smpl(), busy, exp_busy());
      end
      // mid-count write, out-of-range writes, then a write on a reload edge
      wr_en = 1'b0;
      if (d == 1)  begin wr_en = 1'b1; wr_ch = 3'd1; wr_period = 17'd5; end
      if (d >= 4 && d <= 7) begin wr_en = 1'b1; wr_ch = CH_W'(d); wr_period = 17'd1; end
      if (d == 15) begin wr_en = 1'b1; wr_ch = 3'd1; wr_period = 17'd3; end
      tick();
    end
    wr_en = 1'b0;
    en[1] = 1'b0;
    en[2] = 1'b0; en[3] = 1'b0; oneshot[3] = 1'b0;
    tick();
    en[2] = 1'b1; en[3] = 1'b1;
    tick();
    k = cyc;
    for (int i = 0; i < 7; i++) begin
      d = cyc - k;
      ncmp++;
      if (smpl[2] !== (d == 2) || smpl[3] !== (d == 4) ||
          smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL invalid_write_ignored d=%0d smpl=%b want %b", d, smpl, exp_smpl());
      end
      tick();
    end
    en[2] = 1'b0; en[3] = 1'b0;
    tick();
  endtask

  task automatic test_zero_period();
    do_wr(3, 0);
    oneshot[3] = 1'b0; en[3] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ncmp++;
      if (smpl[3] !== 1'b1 || busy[3] !== 1'b1 || smpl !== exp_smpl()) begin
        nerr++; $display("FAIL zero_periodic i=%0d smpl=%b want %b busy=%b", i, smpl, exp_smpl(), busy);
      end
      tick();
    end
    en[3] = 1'b0;
    tick();
    ncmp++;
    if (smpl[3] !== 1'b0 || busy[3] !== 1'b0) begin
      nerr++; $display("FAIL zero_stop smpl[3]=%b busy[3]=%b want 0/0", smpl[3], busy[3]);
    end
    oneshot[3] = 1'b1; en[3] = 1'b1;
    tick();
    ncmp++;
    if (smpl[3] !== 1'b1 || busy[3] !== 1'b1) begin
      nerr++; $display("FAIL zero_oneshot_pulse smpl[3]=%b busy[3]=%b want 1/1", smpl[3], busy[3]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      ncmp++;
      if (smpl[3] !== 1'b0 || busy[3] !== 1'b0 || smpl !== exp_smpl()) begin
        nerr++; $display("FAIL zero_oneshot_after i=%0d smpl=%b want %b busy=%b", i, smpl, exp_smpl(), busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 1; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0)  en[c] = ~en[c];
        if ($urandom_range(0, 15) == 0) oneshot[c] = ~oneshot[c];
      end
      wr_en = ($urandom_range(0, 9) == 0);
      wr_ch = CH_W'($urandom_range(1, 7));
      wr_period = CNT_W'($urandom_range(0, 9));
      tick();
      ncmp++;
      if (smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL random cyc=%0d smpl=%b want %b busy=%b want %b",
                         cyc, smpl, exp_smpl(), busy, exp_busy());
      end
    end
    wr_en = 1'b0;
    en[3:1] = '0; oneshot[3:1] = '0;
  endtask

  // Channel 0 has run on the default period since reset release.
  task automatic test_default_rate();
    while (cyc < ch0_start + 2 * (DEFP + 1) + 1) begin
      tick();
      ncmp++;
      if (smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL default_rate cyc=%0d smpl=%b want %b busy=%b want %b",
                         cyc, smpl, exp_smpl(), busy, exp_busy());
      end
    end
    ncmp++;
    if (p0_q.size() != 2 || p0_q[0] !== ch0_start + DEFP || p0_q[1] !== ch0_start + 2 * DEFP + 1) begin
      nerr++; $display("FAIL default_rate_pulses n=%0d first=%0d second=%0d want 2 at %0d,%0d",
                       p0_q.size(), (p0_q.size() > 0) ? p0_q[0] : -1,
                       (p0_q.size() > 1) ? p0_q[1] : -1, ch0_start + DEFP, ch0_start + 2 * DEFP + 1);
    end
  endtask

  task automatic test_async_reset();
    longint s;
    do_wr(1, 2);
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    ncmp++;
    if (smpl !== 4'b0000 || busy !== 4'b0000) begin
      nerr++; $display("FAIL async_reset_immediate smpl=%b busy=%b want 0000/0000", smpl, busy);
    end
    en = 4'b0001; oneshot = '0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    p0_q.delete();
    tick();
    s = cyc;
    ncmp++;
    if (busy !== 4'b0001 || smpl !== 4'b0000) begin
      nerr++; $display("FAIL async_reset_restart smpl=%b busy=%b want 0000/0001", smpl, busy);
    end
    // ch1 was written before reset; it must be back on the default period
    for (int i = 0; i < 10; i++) tick();
    en[1] = 1'b1;
    while (cyc < s + DEFP + 12) begin
      tick();
      ncmp++;
      if (smpl !== exp_smpl() || busy !== exp_busy()) begin
        nerr++; $display("FAIL after_reset cyc=%0d smpl=%b want %b busy=%b want %b",
                         cyc, smpl, exp_smpl(), busy, exp_busy());
      end
    end
    ncmp++;
    if (p0_q.size() != 1 || p0_q[0] !== s + DEFP) begin
      nerr++; $display("FAIL after_reset_default n=%0d first=%0d want 1 at %0d",
                       p0_q.size(), (p0_q.size() > 0) ? p0_q[0] : -1, s + DEFP);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_period_write();
    test_zero_period();
    test_random();
    test_default_rate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
